// File: rtl/blinky_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : blinky_pkg                                                      |
// | Brief    : Shared mode encoding, mode sequencing and default parameters.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package blinky_pkg;

  typedef enum logic [1:0] {
    BINARY  = 2'd0,
    SCAN    = 2'd1,
    BREATHE = 2'd2,
    FREEZE  = 2'd3
  } mode_t;

  localparam int c_DEF_LEDS_NR    = 6;
  localparam int c_DEF_CTR_W      = 26;
  localparam int c_DEF_TICK_BIT   = 20;
  localparam int c_DEF_DEBOUNCE_W = 16;
  localparam int c_DEF_PWM_W      = 8;

  function automatic mode_t next_mode(input mode_t cur);
    mode_t nxt;
    case (cur)
      BINARY:  nxt = SCAN;
      SCAN:    nxt = BREATHE;
      BREATHE: nxt = FREEZE;
      default: nxt = BINARY;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/blinky_multimode_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : blinky_multimode_if                                             |
// | Brief    : Board-side signals of the blinker: PLL lock, key, LEDs, mode.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface blinky_multimode_if
  import blinky_pkg::*;
#(
  parameter int LEDS_NR = c_DEF_LEDS_NR
);

  logic               pll_lock;
  logic               key;
  logic [LEDS_NR-1:0] led;
  mode_t              mode;

  modport master (
    output pll_lock,
    output key,
    input  led,
    input  mode
  );

  modport slave (
    input  pll_lock,
    input  key,
    output led,
    output mode
  );

endinterface
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : key_debounce                                                    |
// | Brief    : 2-FF key synchroniser, counter debounce, one-cycle press pulse. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module key_debounce
#(
  parameter int DEBOUNCE_W = 16
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  i_key,
  output logic o_key_db,
  output logic o_key_rise
);

  logic                  r_key_meta;
  logic                  r_key_s;
  logic                  r_key_db;
  logic                  r_rise;
  logic [DEBOUNCE_W-1:0] r_cnt;
  logic                  w_accept;

  // The new level is taken once the counter has saturated while still differing.
  assign w_accept = (r_key_s != r_key_db) && (&r_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_meta <= 1'b0;
      r_key_s    <= 1'b0;
      r_key_db   <= 1'b0;
      r_rise     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_key_meta <= i_key;
      r_key_s    <= r_key_meta;
      r_rise     <= w_accept && r_key_s;
      if ((r_key_s == r_key_db) || w_accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DEBOUNCE_W'(1);
      end
      if (w_accept) begin
        r_key_db <= r_key_s;
      end
    end
  end

  assign o_key_db   = r_key_db;
  assign o_key_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/blinky_multimode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : blinky_multimode                                                |
// | Brief    : Four-mode LED blinker (binary, scan, breathe, freeze) gated by  |
// |            PLL lock. Define LED_ACTIVE_LOW_EN for inverted LED drive.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module blinky_multimode
  import blinky_pkg::*;
#(
  parameter int LEDS_NR    = c_DEF_LEDS_NR,
  parameter int CTR_W      = c_DEF_CTR_W,
  parameter int TICK_BIT   = c_DEF_TICK_BIT,
  parameter int DEBOUNCE_W = c_DEF_DEBOUNCE_W,
  parameter int PWM_W      = c_DEF_PWM_W
) (
  input  wire               clk,
  input  wire               rst_n,
  blinky_multimode_if.slave bus
);

  localparam int                 c_POS_W    = (LEDS_NR > 1) ? $clog2(LEDS_NR) : 1;
  localparam logic [c_POS_W-1:0] c_POS_MAX  = c_POS_W'(LEDS_NR - 1);
  localparam logic [PWM_W-1:0]   c_DUTY_MAX = '1;
  localparam logic [LEDS_NR-1:0] c_LED_ALL  = '1;
  localparam logic [LEDS_NR-1:0] c_LED_ONE  = LEDS_NR'(1);

  logic               r_lock_meta;
  logic               r_lock_s;
  logic               w_key_db;
  logic               w_key_rise;
  logic               w_adv;

  mode_t              r_mode;
  mode_t              w_mode_nxt;
  logic [CTR_W-1:0]   r_ctr;
  logic [CTR_W-1:0]   w_ctr_nxt;
  logic [c_POS_W-1:0] r_pos;
  logic [c_POS_W-1:0] w_pos_nxt;
  logic [c_POS_W-1:0] w_pos_step;
  logic               r_scan_dn;
  logic               w_scan_dn_nxt;
  logic               w_scan_dn_step;
  logic [PWM_W-1:0]   r_duty;
  logic [PWM_W-1:0]   w_duty_nxt;
  logic               r_duty_dn;
  logic               w_duty_dn_nxt;
  logic [LEDS_NR-1:0] r_led;
  logic [LEDS_NR-1:0] w_led_nxt;
  logic [LEDS_NR-1:0] r_frz;
  logic [LEDS_NR-1:0] w_frz_nxt;
  logic [LEDS_NR-1:0] w_pat;
  logic               w_run;
  logic               w_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= bus.pll_lock;
      r_lock_s    <= r_lock_meta;
    end
  end

  key_debounce #(
    .DEBOUNCE_W (DEBOUNCE_W)
  ) u_key_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_key      (bus.key),
    .o_key_db   (w_key_db),
    .o_key_rise (w_key_rise)
  );

  // The press pulse coincides with the debounced level going high.
  assign w_adv  = w_key_rise && w_key_db;
  assign w_run  = r_lock_s && (r_mode != FREEZE);
  assign w_tick = w_run && (&r_ctr[TICK_BIT-1:0]);

  generate
    if (LEDS_NR == 1) begin : g_scan_single
      assign w_pos_step     = '0;
      assign w_scan_dn_step = 1'b0;
    end else begin : g_scan_bounce
      always_comb begin
        w_pos_step     = r_pos;
        w_scan_dn_step = r_scan_dn;
        if (!r_scan_dn) begin
          if (r_pos == c_POS_MAX) begin
            w_scan_dn_step = 1'b1;
            w_pos_step     = r_pos - c_POS_W'(1);
          end else begin
            w_pos_step     = r_pos + c_POS_W'(1);
          end
        end else if (r_pos == '0) begin
          w_scan_dn_step = 1'b0;
          w_pos_step     = r_pos + c_POS_W'(1);
        end else begin
          w_pos_step     = r_pos - c_POS_W'(1);
        end
      end
    end
  endgenerate

  // Logical display value for the current mode, before lock gating.
  always_comb begin
    w_pat = '0;
    case (r_mode)
      BINARY:  w_pat = r_ctr[CTR_W-1 -: LEDS_NR];
      SCAN:    w_pat = c_LED_ONE << r_pos;
      BREATHE: w_pat = (r_ctr[PWM_W-1:0] < r_duty) ? c_LED_ALL : '0;
      default: w_pat = r_frz;
    endcase
  end

  always_comb begin
    w_mode_nxt    = r_mode;
    w_ctr_nxt     = r_ctr;
    w_pos_nxt     = r_pos;
    w_scan_dn_nxt = r_scan_dn;
    w_duty_nxt    = r_duty;
    w_duty_dn_nxt = r_duty_dn;
    w_frz_nxt     = r_frz;
    w_led_nxt     = r_lock_s ? w_pat : '0;

    if (w_adv) begin
      w_mode_nxt = next_mode(r_mode);
    end
    if ((w_mode_nxt == FREEZE) && (r_mode != FREEZE)) begin
      w_frz_nxt = w_pat;
    end
    if (w_run) begin
      w_ctr_nxt = r_ctr + CTR_W'(1);
    end
    // Ticks act under the mode in force this cycle, even if it is changing.
    if (w_tick && (r_mode == SCAN)) begin
      w_pos_nxt     = w_pos_step;
      w_scan_dn_nxt = w_scan_dn_step;
    end
    if (w_tick && (r_mode == BREATHE)) begin
      if (!r_duty_dn) begin
        if (r_duty == c_DUTY_MAX) begin
          w_duty_dn_nxt = 1'b1;
          w_duty_nxt    = r_duty - PWM_W'(1);
        end else begin
          w_duty_nxt    = r_duty + PWM_W'(1);
        end
      end else if (r_duty == '0) begin
        w_duty_dn_nxt = 1'b0;
        w_duty_nxt    = r_duty + PWM_W'(1);
      end else begin
        w_duty_nxt    = r_duty - PWM_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= BINARY;
      r_ctr     <= '0;
      r_pos     <= '0;
      r_scan_dn <= 1'b0;
      r_duty    <= '0;
      r_duty_dn <= 1'b0;
      r_frz     <= '0;
      r_led     <= '0;
    end else begin
      r_mode    <= w_mode_nxt;
      r_ctr     <= w_ctr_nxt;
      r_pos     <= w_pos_nxt;
      r_scan_dn <= w_scan_dn_nxt;
      r_duty    <= w_duty_nxt;
      r_duty_dn <= w_duty_dn_nxt;
      r_frz     <= w_frz_nxt;
      r_led     <= w_led_nxt;
    end
  end

  assign bus.mode = r_mode;
`ifdef LED_ACTIVE_LOW_EN
  assign bus.led  = ~r_led;
`else
  assign bus.led  = r_led;
`endif

endmodule
`default_nettype wire

// File: tb/tb_blinky_multimode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_blinky_multimode                                             |
// | Brief    : Randomised key/lock stimulus against a behavioural blinker model.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_blinky_multimode;
  import blinky_pkg::*;

  localparam int LEDS_NR    = 4;
  localparam int CTR_W      = 8;
  localparam int TICK_BIT   = 2;
  localparam int DEBOUNCE_W = 3;
  localparam int PWM_W      = 2;
  localparam int c_LED_MASK = (1 << LEDS_NR) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  blinky_multimode_if #(.LEDS_NR(LEDS_NR)) bus ();

  blinky_multimode #(
    .LEDS_NR    (LEDS_NR),
    .CTR_W      (CTR_W),
    .TICK_BIT   (TICK_BIT),
    .DEBOUNCE_W (DEBOUNCE_W),
    .PWM_W      (PWM_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int phys(input int v);
`ifdef LED_ACTIVE_LOW_EN
    return (~v) & c_LED_MASK;
`else
    return v & c_LED_MASK;
`endif
  endfunction

  // Triangle wave 0..top..0.. indexed by how many steps have been taken.
  function automatic int tri_wave(input int n, input int top);
    int p;
    if (top == 0) return 0;
    p = n % (2 * top);
    return (p <= top) ? p : 2 * top - p;
  endfunction

  // Reference state: counts of ticks spent in each pattern rather than positions.
  int m_lk0 = 0, m_lk1 = 0, m_ky0 = 0, m_ky1 = 0;
  int m_db = 0, m_streak = 0, m_rise = 0;
  int m_mode = 0, m_ctr = 0, m_scan_n = 0, m_brth_n = 0, m_frz = 0, m_led = 0;

  function automatic int pattern(input int md);
    case (md)
      0: return (m_ctr >> (CTR_W - LEDS_NR)) & c_LED_MASK;
      1: return 1 << tri_wave(m_scan_n, LEDS_NR - 1);
      2: return ((m_ctr % (1 << PWM_W)) < tri_wave(m_brth_n, (1 << PWM_W) - 1)) ? c_LED_MASK : 0;
      default: return m_frz;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lk0 = 0; m_lk1 = 0; m_ky0 = 0; m_ky1 = 0;
      m_db = 0; m_streak = 0; m_rise = 0;
      m_mode = 0; m_ctr = 0; m_scan_n = 0; m_brth_n = 0; m_frz = 0; m_led = 0;
    end else begin : step
      int run, tick, nmode, pat;
      run   = (m_lk1 != 0) && (m_mode != 3);
      tick  = run && ((m_ctr % (1 << TICK_BIT)) == (1 << TICK_BIT) - 1);
      pat   = pattern(m_mode);
      m_led = (m_lk1 != 0) ? pat : 0;
      nmode = (m_rise != 0) ? (m_mode + 1) % 4 : m_mode;
      if (m_mode != 3 && nmode == 3) m_frz = pat;
      if (tick && m_mode == 1) m_scan_n++;
      if (tick && m_mode == 2) m_brth_n++;
      if (run) m_ctr = (m_ctr + 1) % (1 << CTR_W);
      m_mode = nmode;
      m_rise = 0;
      if (m_ky1 != m_db) begin
        m_streak++;
        if (m_streak == (1 << DEBOUNCE_W)) begin
          m_db     = m_ky1;
          m_streak = 0;
          m_rise   = m_db;
        end
      end else begin
        m_streak = 0;
      end
      m_lk1 = m_lk0; m_lk0 = int'(bus.pll_lock);
      m_ky1 = m_ky0; m_ky0 = int'(bus.key);
    end
  end

  always @(negedge clk) begin
    chk("led", int'(bus.led), phys(m_led));
    chk("mode", int'(bus.mode), m_mode);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hold, input int gap);
    bus.key = 1'b1;
    cyc(hold);
    bus.key = 1'b0;
    cyc(gap);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    bus.pll_lock = 1'b1;
    bus.key      = 1'b0;
    cyc(3);
    chk("rst_led", int'(bus.led), phys(0));
    chk("rst_mode", int'(bus.mode), 0);
    rst_n = 1'b1;
    cyc(18);
    chk("bin_ctr15", int'(bus.led), phys(0));
    cyc(1);
    chk("bin_ctr16", int'(bus.led), phys(1));

    press(3, 20);
    chk("glitch_mode", int'(bus.mode), 0);
    press(12, 20);
    chk("press1_mode", int'(bus.mode), 1);
    press(12, 20);
    chk("press2_mode", int'(bus.mode), 2);

    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5) begin
        press(int'($urandom_range(1, 14)), int'($urandom_range(1, 14)));
      end else if (r < 7) begin
        bus.pll_lock = 1'b0;
        cyc(int'($urandom_range(1, 20)));
        bus.pll_lock = 1'b1;
        cyc(int'($urandom_range(1, 10)));
      end else begin
        cyc(int'($urandom_range(5, 60)));
      end
    end
    cyc(20);

    for (int i = 0; i < 5 && m_mode != 3; i++) press(12, 20);
    chk("frz_mode", int'(bus.mode), 3);
    cyc(100);
    chk("frz_hold", int'(bus.led), phys(m_frz));
    bus.pll_lock = 1'b0;
    cyc(3);
    chk("lockloss_led", int'(bus.led), phys(0));
    bus.pll_lock = 1'b1;
    cyc(4);
    chk("frz_resume", int'(bus.led), phys(m_frz));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/blinky_multimode.md
Name: blinky_multimode

Overview:
- Parametrised successor to the single-counter LED blinker.
- Sits behind the PLL output clock.
- Gates counting on a synchronised PLL-lock input and debounces the user key.
- Cycles through four LED display modes, stepping one mode per key press: binary counter, bouncing scanner, PWM "breathe", freeze.

Parameters:
- LEDS_NR, 6, number of LED outputs (1..16).
- CTR_W, 26, free-running counter width; must be > TICK_BIT and >= LEDS_NR.
- TICK_BIT, 20, pattern step tick fires when ctr_q[TICK_BIT-1:0] is all ones.
- DEBOUNCE_W, 16, debounce counter width; a change is accepted after 2^DEBOUNCE_W-1 stable cycles.
- PWM_W, 8, breathe duty width; must be <= TICK_BIT.

Ports:
- clk  in  1  PLL output clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- pll_lock  in  1  PLL lock, asynchronous to clk.
- key  in  1  raw pushbutton, asynchronous; 1 = pressed.
- led  out  LEDS_NR  LED drive; 1 = on.
- mode  out  2  current mode: 0 BINARY, 1 SCAN, 2 BREATHE, 3 FREEZE.

Behaviour:
- Reset (rst_n low, asynchronous): every register is cleared, so ctr_q=0, mode=BINARY, led=0, scan pos=0, scan dir=up, duty=0, duty dir=up, debounced key=0, debounce counter=0, lock sync=0.
- Synchronisers: pll_lock and key each pass through a 2-FF synchroniser, giving lock_s and key_s (2-cycle latency).
- Debounce:
  - The counter clears whenever key_s == key_db.
  - Otherwise it increments.
  - When it reaches all ones while key_s != key_db: key_db <= key_s and the counter clears.
  - Glitches shorter than 2^DEBOUNCE_W-1 cycles are rejected.
- Mode FSM:
  - A rising edge of key_db advances the mode BINARY->SCAN->BREATHE->FREEZE->BINARY.
  - A falling edge has no effect.
  - Mode changes even while lock_s=0.
- run = lock_s && mode != FREEZE.
- Counter:
  - While run=1, ctr_q increments by 1 every cycle and wraps from all ones to 0.
  - It holds otherwise.
- tick = run && ctr_q[TICK_BIT-1:0] == all ones; one-cycle pulse.
- SCAN:
  - On tick, pos moves one step in dir.
  - At pos==LEDS_NR-1 going up, dir flips and pos moves to LEDS_NR-2. At pos==0 going down, the mirror case applies.
  - If LEDS_NR==1, pos stays 0.
  - led = one-hot(pos).
- BREATHE:
  - On tick, duty steps ±1.
  - At all ones going up, dir flips to down and duty decrements. At 0 going down, dir flips to up.
  - led = all ones when ctr_q[PWM_W-1:0] < duty, else 0; duty=0 gives fully off.
- BINARY: led = ctr_q[CTR_W-1 -: LEDS_NR].
- Pattern state persistence: pos/dir/duty update only in their own mode and hold their values across mode switches.
- FREEZE:
  - led is a registered copy of the last displayed value, captured on the cycle the mode enters FREEZE.
  - The counter holds.
- Lock loss (lock_s=0): led forced to 0 (applies in every mode), counter and pattern state hold. Display resumes from the held state when lock returns.
- Output timing: led and mode are registered; led reflects the state of the previous cycle.
- Simultaneous tick and mode change: the tick applies under the old mode; the new mode takes effect next cycle.

Optional Feature:
- Macro: LED_ACTIVE_LOW_EN.
- Defined: led port driven as the bitwise inverse of the logical value; reset value is all ones (LEDs off on boards with active-low LEDs).
- Undefined: led is active-high with reset value 0.
- The mode port is unaffected either way.

Decomposition:
- Shared package blinky_pkg:
  - mode_t enum (BINARY=2'd0, SCAN=2'd1, BREATHE=2'd2, FREEZE=2'd3).
  - next_mode function.
  - Default parameter constants.
- Sub-module key_debounce: 2-FF sync plus debounce counter; output key_db and a one-cycle rise pulse; parameter DEBOUNCE_W.
- Counter, FSM and pattern generators stay in the top module.

Test Plan (LEDS_NR=4, CTR_W=8, TICK_BIT=2, DEBOUNCE_W=3, PWM_W=2):
- Reset then lock: rst_n low with pll_lock=1 -> led=0, mode=0; release rst_n -> ctr_q increments from the 3rd cycle; led=ctr_q[7:4], reaching 4'h1 after 16 increments.
- Debounce: 3-cycle key pulse -> mode stays 0; key held high for 12 cycles -> mode=1 exactly once; release and re-press -> mode=2.
- Scan bounce in SCAN: led sequence over successive ticks is 0001,0010,0100,1000,0100,0010,0001,0010; ticks are 4 cycles apart.
- Breathe in BREATHE: duty over ticks is 0,1,2,3,2,1,0,1; with duty=2, led=4'hF for exactly 2 of every 4 cycles.
- Freeze and lock loss: enter FREEZE with led=4'h5 -> led stays 4'h5 for 100 cycles and ctr_q is constant; drop pll_lock -> led=0 within 3 cycles; restore lock -> led=4'h5 again.
- Macro LED_ACTIVE_LOW_EN: rerun the reset test -> led=4'hF during reset; led is the bitwise inverse of the non-macro run on every cycle.
